alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback stage around the 8-bit combinational ALU.
// Ports: clk/rst_n (sync, active-low); instr_valid/instr_ready/instr handshake;
//        alu_a/alu_b/alu_a_m/alu_b_m/alu_opcode to the ALU, alu_result/alu_flag back;
//        res_valid/res_data/res_flag/res_rd completion; flag_q status; dbg_addr/dbg_data RF peek.
module alu_sequencer #(
    parameter logic [7:0] RF_INIT     = 8'h00,
    parameter bit         FLAG_STICKY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_a_m,
    output logic [3:0]  alu_b_m,
    output logic [2:0]  alu_opcode,
    input  logic [7:0]  alu_result,
    input  logic        alu_flag,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        res_flag,
    output logic [1:0]  res_rd,
    output logic        flag_q,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0] rf [4];
    logic [1:0] rd_q;
    logic       accept;

    logic       is_ldi;
    logic [2:0] dec_op;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs1;
    logic [1:0] dec_rs2;
    logic [1:0] ldi_rd;
    logic [7:0] ldi_imm;

    assign is_ldi  = instr[15];
    assign dec_op  = instr[14:12];
    assign dec_rd  = instr[11:10];
    assign dec_rs1 = instr[9:8];
    assign dec_rs2 = instr[7:6];
    assign ldi_rd  = instr[14:13];
    assign ldi_imm = instr[7:0];

    assign dbg_data = rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = is_ldi ? DONE : EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= RF_INIT;
            end
            rd_q       <= 2'd0;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_a_m    <= 4'd0;
            alu_b_m    <= 4'd0;
            alu_opcode <= 3'd0;
            res_data   <= 8'd0;
            res_flag   <= 1'b0;
            res_rd     <= 2'd0;
            flag_q     <= 1'b0;
        end else begin
            // Operands are sampled at the accept edge, so rd==rs reads the old value.
            if (accept && !is_ldi) begin
                alu_a      <= rf[dec_rs1];
                alu_b      <= rf[dec_rs2];
                alu_a_m    <= rf[dec_rs1][3:0];
                alu_b_m    <= rf[dec_rs2][3:0];
                alu_opcode <= dec_op;
                rd_q       <= dec_rd;
            end
            // LDI writes back immediately and leaves flag_q alone.
            if (accept && is_ldi) begin
                rf[ldi_rd] <= ldi_imm;
                res_data   <= ldi_imm;
                res_flag   <= 1'b0;
                res_rd     <= ldi_rd;
            end
            if (state_q == EXEC) begin
                rf[rd_q] <= alu_result;
                res_data <= alu_result;
                res_flag <= alu_flag;
                res_rd   <= rd_q;
                flag_q   <= FLAG_STICKY ? (flag_q | alu_flag) : alu_flag;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives two alu_sequencer instances (default and sticky/RF_INIT=3C)
// with a behavioural ALU, a vector table, corner sequences and random instructions.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0;
    logic [1:0]  dbg_addr = 2'd0;

    logic       instr_ready [2];
    logic [7:0] alu_a [2];
    logic [7:0] alu_b [2];
    logic [3:0] alu_a_m [2];
    logic [3:0] alu_b_m [2];
    logic [2:0] alu_opcode [2];
    logic [7:0] alu_result [2];
    logic       alu_flag [2];
    logic       res_valid [2];
    logic [7:0] res_data [2];
    logic       res_flag [2];
    logic [1:0] res_rd [2];
    logic       flag_q [2];
    logic [7:0] dbg_data [2];

    int n_tests = 0;
    int n_fail = 0;

    localparam logic [7:0] INIT0 = 8'h00;
    localparam logic [7:0] INIT1 = 8'h3C;

    always #5 clk = ~clk;

    alu_sequencer #(.RF_INIT(INIT0), .FLAG_STICKY(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready[0]), .instr(instr),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_a_m(alu_a_m[0]), .alu_b_m(alu_b_m[0]), .alu_opcode(alu_opcode[0]),
        .alu_result(alu_result[0]), .alu_flag(alu_flag[0]),
        .res_valid(res_valid[0]), .res_data(res_data[0]),
        .res_flag(res_flag[0]), .res_rd(res_rd[0]), .flag_q(flag_q[0]),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data[0])
    );

    alu_sequencer #(.RF_INIT(INIT1), .FLAG_STICKY(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready[1]), .instr(instr),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_a_m(alu_a_m[1]), .alu_b_m(alu_b_m[1]), .alu_opcode(alu_opcode[1]),
        .alu_result(alu_result[1]), .alu_flag(alu_flag[1]),
        .res_valid(res_valid[1]), .res_data(res_data[1]),
        .res_flag(res_flag[1]), .res_rd(res_rd[1]), .flag_q(flag_q[1]),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data[1])
    );

    // Behavioural ALU: ADD carry, SUB borrow, 4x4 MUL, logic ops, shift, pass.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [3:0] am,
                                         input logic [3:0] bm);
        int s;
        logic [8:0] r;
        r = 9'd0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r = {s > 255, 8'(s)}; end
            3'd1: begin s = int'(a) - int'(b); r = {a < b, 8'(s)}; end
            3'd2: begin s = int'(am) * int'(bm); r = {s > 255, 8'(s)}; end
            3'd3: r = {1'b0, a & b};
            3'd4: r = {1'b0, a | b};
            3'd5: r = {1'b0, a ^ b};
            3'd6: r = {a[7], a << 1};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    always_comb {alu_flag[0], alu_result[0]} =
        alu_f(alu_opcode[0], alu_a[0], alu_b[0], alu_a_m[0], alu_b_m[0]);
    always_comb {alu_flag[1], alu_result[1]} =
        alu_f(alu_opcode[1], alu_a[1], alu_b[1], alu_a_m[1], alu_b_m[1]);

    // Reference model: architectural register file and flag per instance.
    logic [7:0] mrf [2][4];
    logic       mfq [2];
    localparam bit STICKY0 = 1'b0;
    localparam bit STICKY1 = 1'b1;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mrf[0][i] = INIT0;
            mrf[1][i] = INIT1;
        end
        mfq[0] = 1'b0;
        mfq[1] = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] w, output logic [1:0][7:0] ed,
                              output logic [1:0] ef, output logic [1:0] rd);
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] r;
        rd = w[15] ? w[14:13] : w[11:10];
        for (int d = 0; d < 2; d++) begin
            if (w[15]) begin
                ed[d] = w[7:0];
                ef[d] = 1'b0;
            end else begin
                a = mrf[d][w[9:8]];
                b = mrf[d][w[7:6]];
                r = alu_f(w[14:12], a, b, a[3:0], b[3:0]);
                ed[d] = r[7:0];
                ef[d] = r[8];
                if ((d == 0 && STICKY0) || (d == 1 && STICKY1))
                    mfq[d] = mfq[d] | r[8];
                else
                    mfq[d] = r[8];
            end
            mrf[d][rd] = ed[d];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one instruction, follow it to completion and check everything on the way.
    task automatic issue(input logic [15:0] w, output logic [7:0] od, output logic of,
                         output logic ofq0, output logic ofq1);
        logic [1:0][7:0] ea;
        logic [1:0][7:0] eb;
        logic [1:0][7:0] ed;
        logic [1:0]      ef;
        logic [1:0]      rd;
        int waitc;
        int lat;
        for (int d = 0; d < 2; d++) begin
            ea[d] = mrf[d][w[9:8]];
            eb[d] = mrf[d][w[7:6]];
        end
        model_step(w, ed, ef, rd);
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        waitc = 0;
        while (!instr_ready[0] && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk("accept_wait", 32'(waitc < 10), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        if (!w[15]) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("alu_a%0d", d), 32'(alu_a[d]), 32'(ea[d]));
                chk($sformatf("alu_b%0d", d), 32'(alu_b[d]), 32'(eb[d]));
                chk($sformatf("alu_a_m%0d", d), 32'(alu_a_m[d]), 32'(ea[d][3:0]));
                chk($sformatf("alu_b_m%0d", d), 32'(alu_b_m[d]), 32'(eb[d][3:0]));
                chk($sformatf("alu_op%0d", d), 32'(alu_opcode[d]), 32'(w[14:12]));
                chk($sformatf("exec_ready%0d", d), 32'(instr_ready[d]), 32'd0);
            end
        end
        while (!res_valid[0] && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), w[15] ? 32'd1 : 32'd2);
        dbg_addr = rd;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("res_valid%0d", d), 32'(res_valid[d]), 32'd1);
            chk($sformatf("res_data%0d", d), 32'(res_data[d]), 32'(ed[d]));
            chk($sformatf("res_flag%0d", d), 32'(res_flag[d]), 32'(ef[d]));
            chk($sformatf("res_rd%0d", d), 32'(res_rd[d]), 32'(rd));
            chk($sformatf("flag_q%0d", d), 32'(flag_q[d]), 32'(mfq[d]));
            chk($sformatf("done_ready%0d", d), 32'(instr_ready[d]), 32'd0);
            chk($sformatf("dbg%0d", d), 32'(dbg_data[d]), 32'(ed[d]));
        end
        od = res_data[0];
        of = res_flag[0];
        ofq0 = flag_q[0];
        ofq1 = flag_q[1];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("strobe_end%0d", d), 32'(res_valid[d]), 32'd0);
            chk($sformatf("idle_ready%0d", d), 32'(instr_ready[d]), 32'd1);
            chk($sformatf("res_hold%0d", d), 32'(res_data[d]), 32'(ed[d]));
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic [7:0]  d;
        logic        f;
        logic        fq0;
        logic        fq1;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic [1:0] rd;
    } res_t;

    vec_t tbl [15];

    task automatic check_reset_state();
        logic [7:0] init;
        for (int d = 0; d < 2; d++) begin
            init = (d == 0) ? INIT0 : INIT1;
            chk($sformatf("rst_ready%0d", d), 32'(instr_ready[d]), 32'd1);
            chk($sformatf("rst_valid%0d", d), 32'(res_valid[d]), 32'd0);
            chk($sformatf("rst_data%0d", d), 32'(res_data[d]), 32'd0);
            chk($sformatf("rst_flag%0d", d), 32'(res_flag[d]), 32'd0);
            chk($sformatf("rst_rd%0d", d), 32'(res_rd[d]), 32'd0);
            chk($sformatf("rst_flag_q%0d", d), 32'(flag_q[d]), 32'd0);
            chk($sformatf("rst_alu%0d", d),
                32'({alu_a[d], alu_b[d], alu_a_m[d], alu_b_m[d], alu_opcode[d]}), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("rst_rf0_%0d", i), 32'(dbg_data[0]), 32'(INIT0));
            chk($sformatf("rst_rf1_%0d", i), 32'(dbg_data[1]), 32'(INIT1));
        end
    endtask

    initial begin
        logic [7:0]  od;
        logic        of;
        logic        ofq0;
        logic        ofq1;
        logic [15:0] ws [3];
        int          acc [3];
        int          idx;
        int          nres;
        res_t        q [$];
        res_t        e;
        logic [1:0][7:0] ed;
        logic [1:0]      ef;
        logic [1:0]      rd;

        tbl[0]  = '{16'h8005, 8'h05, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{16'hA003, 8'h03, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{16'h0840, 8'h08, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{16'h80E1, 8'hE1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{16'hA032, 8'h32, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{16'h0840, 8'h13, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{16'h8064, 8'h64, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{16'hA0CD, 8'hCD, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{16'h1840, 8'h97, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{16'h80FF, 8'hFF, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{16'hA00F, 8'h0F, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{16'h2840, 8'hE1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{16'h8007, 8'h07, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{16'h0000, 8'h0E, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{16'h0000, 8'h1C, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_state();

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].w, od, of, ofq0, ofq1);
            chk($sformatf("tbl%0d_data", i), 32'(od), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_flag", i), 32'(of), 32'(tbl[i].f));
            chk($sformatf("tbl%0d_fq0", i), 32'(ofq0), 32'(tbl[i].fq0));
            chk($sformatf("tbl%0d_fq1", i), 32'(ofq1), 32'(tbl[i].fq1));
        end

        // Continuous valid with a dependent chain of three ALU ops.
        issue(16'h800A, od, of, ofq0, ofq1);
        issue(16'hA014, od, of, ofq0, ofq1);
        ws[0] = 16'h0840;
        ws[1] = 16'h1E00;
        ws[2] = 16'h0380;
        @(negedge clk);
        instr = ws[0];
        instr_valid = 1'b1;
        idx = 0;
        nres = 0;
        for (int c = 0; c < 20 && nres < 3; c++) begin
            if (res_valid[0]) begin
                chk("stream_ready_done", 32'(instr_ready[0]), 32'd0);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("stream_data", 32'(res_data[0]), 32'(e.d));
                    chk("stream_flag", 32'(res_flag[0]), 32'(e.f));
                    chk("stream_rd", 32'(res_rd[0]), 32'(e.rd));
                end else begin
                    chk("stream_extra_result", 32'd1, 32'd0);
                end
                nres++;
            end
            if (instr_ready[0] && instr_valid && idx < 3) begin
                acc[idx] = c;
                model_step(ws[idx], ed, ef, rd);
                q.push_back('{ed[0], ef[0], rd});
                idx++;
            end
            @(negedge clk);
            if (idx < 3) instr = ws[idx];
            else instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        chk("stream_results", 32'(nres), 32'd3);
        chk("stream_accepts", 32'(idx), 32'd3);
        chk("stream_gap01", 32'(acc[1] - acc[0]), 32'd3);
        chk("stream_gap12", 32'(acc[2] - acc[1]), 32'd3);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("stream_rf%0d", i), 32'(dbg_data[0]), 32'(mrf[0][i]));
        end

        // Reset during EXEC of SUB r3 abandons the writeback.
        issue(16'hE009, od, of, ofq0, ofq1);
        issue(16'h80FF, od, of, ofq0, ofq1);
        issue(16'h0040, od, of, ofq0, ofq1);
        @(negedge clk);
        instr = 16'h1C40;
        instr_valid = 1'b1;
        chk("mid_pre_ready", 32'(instr_ready[0]), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_exec_op", 32'(alu_opcode[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid0", 32'(res_valid[0]), 32'd0);
        chk("mid_rst_valid1", 32'(res_valid[1]), 32'd0);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            chk("mid_no_strobe0", 32'(res_valid[0]), 32'd0);
            chk("mid_no_strobe1", 32'(res_valid[1]), 32'd0);
            @(negedge clk);
        end
        check_reset_state();

        // Random instructions, reserved fields included.
        for (int i = 0; i < 40; i++) begin
            issue(16'($urandom), od, of, ofq0, ofq1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
